// File: rtl/muldiv_ctrl_if.sv
// Pipeline-side bundle for the HI/LO multiply/divide sequencer.
// Master is the EX stage (decoder/hazard unit); slave is muldiv_ctrl.
interface muldiv_ctrl_if #(
    parameter int WIDTH = 32
);
    // Handshake: op_valid_E stays high while the instruction sits in EX. The sequencer
    // accepts it only when idle and not flushed. stall_muldiv holds IF..EX until the
    // result is ready. result_valid marks the cycles in which {hi_out, lo_out} is the
    // HILO write data. The master must drop or replace op_valid_E on the edge where the
    // pipeline advances past DONE (stall_other low), or the op is accepted again.
    logic             op_valid_E;
    logic [1:0]       op_E;
    logic [WIDTH-1:0] src_a_E;
    logic [WIDTH-1:0] src_b_E;
    logic             flush_E;
    logic             stall_other;
    logic             stall_muldiv;
    logic             result_valid;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    modport master (
        output op_valid_E, op_E, src_a_E, src_b_E, flush_E, stall_other,
        input  stall_muldiv, result_valid, hi_out, lo_out
    );

    modport slave (
        input  op_valid_E, op_E, src_a_E, src_b_E, flush_E, stall_other,
        output stall_muldiv, result_valid, hi_out, lo_out
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// HI/LO sequencer: counted multiply or radix-2 restoring divide, with pipeline stall,
// flush abort and a result held in DONE until the pipeline advances.
module muldiv_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int WIDTH      = 32
) (
    input  logic           clk,
    input  logic           resetn,
    muldiv_ctrl_if.slave   bus,
    output logic [1:0]     state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int            CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

    state_t             state;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               op_signed_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quot_q;
    logic [WIDTH-1:0]   dvsr_q;
    logic               dvsr_zero_q;
    logic               neg_quot_q;
    logic               neg_rem_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               valid_q;

    logic               start;
    logic               start_signed;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] product;

    logic [WIDTH:0]     trial;
    logic [WIDTH:0]     diff;
    logic               q_bit;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quot_next;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign start        = bus.op_valid_E & ~bus.flush_E;
    assign start_signed = ~bus.op_E[0];

    // The divider works on magnitudes; signs are reapplied when the result is written.
    assign a_mag = (start_signed && bus.src_a_E[WIDTH-1]) ? -bus.src_a_E : bus.src_a_E;
    assign b_mag = (start_signed && bus.src_b_E[WIDTH-1]) ? -bus.src_b_E : bus.src_b_E;

    // Sign- or zero-extend to the full product width so one unsigned multiply serves both.
    assign ext_a   = op_signed_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    assign ext_b   = op_signed_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    assign product = ext_a * ext_b;

    // One restoring step: shift the next dividend bit into the partial remainder.
    assign trial     = {rem_q, quot_q[WIDTH-1]};
    assign diff      = trial - {1'b0, dvsr_q};
    assign q_bit     = ~diff[WIDTH];
    assign rem_next  = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quot_next = {quot_q[WIDTH-2:0], q_bit};
    assign quot_fix  = neg_quot_q ? -quot_next : quot_next;
    assign rem_fix   = neg_rem_q  ? -rem_next  : rem_next;

    always_comb begin
        bus.stall_muldiv = 1'b0;
        if (resetn && !bus.flush_E) begin
            bus.stall_muldiv = ((state == IDLE) && bus.op_valid_E) ||
                               (state == MUL) || (state == DIV);
        end
    end

    assign bus.result_valid = valid_q;
    assign bus.hi_out       = hi_q;
    assign bus.lo_out       = lo_q;
    assign state_dbg        = state;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            count       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_signed_q <= 1'b0;
            rem_q       <= '0;
            quot_q      <= '0;
            dvsr_q      <= '0;
            dvsr_zero_q <= 1'b0;
            neg_quot_q  <= 1'b0;
            neg_rem_q   <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            valid_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    valid_q <= 1'b0;
                    if (start) begin
                        a_q         <= bus.src_a_E;
                        b_q         <= bus.src_b_E;
                        op_signed_q <= start_signed;
                        count       <= '0;
                        rem_q       <= '0;
                        quot_q      <= a_mag;
                        dvsr_q      <= b_mag;
                        dvsr_zero_q <= (bus.src_b_E == '0);
                        neg_quot_q  <= start_signed & (bus.src_a_E[WIDTH-1] ^ bus.src_b_E[WIDTH-1]);
                        neg_rem_q   <= start_signed & bus.src_a_E[WIDTH-1];
                        state       <= bus.op_E[1] ? DIV : MUL;
                    end
                end
                MUL: begin
                    if (bus.flush_E) begin
                        count <= '0;
                        state <= IDLE;
                    end else begin
                        count <= count + CW'(1);
                        if (count == MUL_LAST) begin
                            hi_q    <= product[2*WIDTH-1:WIDTH];
                            lo_q    <= product[WIDTH-1:0];
                            valid_q <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end
                DIV: begin
                    if (bus.flush_E) begin
                        count <= '0;
                        state <= IDLE;
                    end else begin
                        count  <= count + CW'(1);
                        rem_q  <= rem_next;
                        quot_q <= quot_next;
                        if (count == DIV_LAST) begin
                            // Divide by zero returns the dividend in HI and all-ones in LO.
                            if (dvsr_zero_q) begin
                                hi_q <= a_q;
                                lo_q <= '1;
                            end else begin
                                hi_q <= rem_fix;
                                lo_q <= quot_fix;
                            end
                            valid_q <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Hold the result while the pipeline is frozen elsewhere; one write only.
                    if (bus.flush_E || !bus.stall_other) begin
                        valid_q <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: per-cycle reference model plus a literal-result
// scoreboard, directed MULT/MULTU/DIV/DIVU vectors, flush, stall_other hold and reset.
module tb_muldiv_ctrl;

    localparam int WIDTH      = 32;
    localparam int MUL_CYCLES = 4;
    localparam int MUL_LAT    = MUL_CYCLES + 1;
    localparam int DIV_LAT    = 33;

    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       resetn;
    logic [1:0] state_dbg;

    always #5 clk = ~clk;

    muldiv_ctrl_if #(.WIDTH(WIDTH)) bus ();

    muldiv_ctrl #(.MUL_CYCLES(MUL_CYCLES), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference arithmetic ----------------
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = '0;
        case (op)
            OP_MULT:  r = 64'(sa * sb);
            OP_MULTU: r = {32'd0, a} * {32'd0, b};
            OP_DIV: begin
                if (b == 32'd0) r = {a, 32'hffff_ffff};
                else            r = {32'(sa % sb), 32'(sa / sb)};
            end
            default: begin
                if (b == 32'd0) r = {a, 32'hffff_ffff};
                else            r = {a % b, a / b};
            end
        endcase
        return r;
    endfunction

    // ---------------- model + compare + scoreboard ----------------
    int          m_busy  = 0;
    bit          m_valid = 1'b0;
    logic [31:0] m_hi    = '0;
    logic [31:0] m_lo    = '0;
    logic [63:0] m_pend  = '0;
    logic        prev_valid = 1'b0;
    logic [63:0] exp_q[$];

    always @(negedge clk) begin
        logic exp_stall;
        logic m_idle;
        if (!resetn) begin
            m_busy  = 0;
            m_valid = 1'b0;
            m_hi    = '0;
            m_lo    = '0;
        end
        m_idle    = (m_busy == 0) && !m_valid;
        exp_stall = resetn && !bus.flush_E && ((m_idle && bus.op_valid_E) || (m_busy > 0));

        check("stall_muldiv", 64'(bus.stall_muldiv), 64'(exp_stall));
        check("result_valid", 64'(bus.result_valid), 64'(m_valid));
        check("hi_out", 64'(bus.hi_out), 64'(m_hi));
        check("lo_out", 64'(bus.lo_out), 64'(m_lo));

        if (bus.result_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected_write: got %h_%h expected none", bus.hi_out, bus.lo_out);
            end else begin
                check("sb_result", {bus.hi_out, bus.lo_out}, exp_q.pop_front());
            end
        end
        prev_valid = resetn ? bus.result_valid : 1'b0;

        if (resetn) begin
            if (bus.flush_E) begin
                m_busy  = 0;
                m_valid = 1'b0;
            end else if (m_idle) begin
                if (bus.op_valid_E) begin
                    m_busy = bus.op_E[1] ? 32 : MUL_CYCLES;
                    m_pend = ref_result(bus.op_E, bus.src_a_E, bus.src_b_E);
                end
            end else if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_valid      = 1'b1;
                    {m_hi, m_lo} = m_pend;
                end
            end else if (!bus.stall_other) begin
                m_valid = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input int elat, input int hold);
        int stalls;
        int cyc;
        int vcnt;
        exp_q.push_back({ehi, elo});
        @(posedge clk); #1;
        bus.op_valid_E  = 1'b1;
        bus.op_E        = op;
        bus.src_a_E     = a;
        bus.src_b_E     = b;
        bus.stall_other = (hold > 0);
        stalls = 0;
        cyc    = 0;
        forever begin
            @(negedge clk);
            if (bus.result_valid || cyc > 100) break;
            if (bus.stall_muldiv) stalls++;
            cyc++;
        end
        if (cyc > 100) begin
            total++;
            bad++;
            $display("FAIL op_timeout: got no result_valid after %0d cycles expected %0d", cyc, elat);
            @(posedge clk); #1;
            bus.op_valid_E  = 1'b0;
            bus.stall_other = 1'b0;
            return;
        end
        check("latency", 64'(cyc), 64'(elat));
        check("stall_cycles", 64'(stalls), 64'(elat));
        vcnt = 1;
        for (int k = 1; k <= hold; k++) begin
            @(posedge clk); #1;
            if (k == hold) bus.stall_other = 1'b0;
            @(negedge clk);
            if (bus.result_valid) vcnt++;
        end
        check("valid_cycles", 64'(vcnt), 64'(hold + 1));
        @(posedge clk); #1;
        bus.op_valid_E = 1'b0;
    endtask

    task automatic flush_test();
        int rv_seen;
        @(posedge clk); #1;
        bus.op_valid_E = 1'b1;
        bus.op_E       = OP_DIV;
        bus.src_a_E    = 32'd1000;
        bus.src_b_E    = 32'd3;
        @(negedge clk);
        check("flush_issue_stall", 64'(bus.stall_muldiv), 64'd1);
        repeat (10) @(posedge clk);
        #1 bus.flush_E = 1'b1;
        @(negedge clk);
        check("flush_stall_same_cycle", 64'(bus.stall_muldiv), 64'd0);
        // Next cycle: back in IDLE, flush still high together with op_valid -> no start.
        @(posedge clk); #1;
        @(negedge clk);
        check("flush_idle_state", 64'(state_dbg), 64'd0);
        check("flush_idle_no_stall", 64'(bus.stall_muldiv), 64'd0);
        @(posedge clk); #1;
        bus.flush_E    = 1'b0;
        bus.op_valid_E = 1'b0;
        @(negedge clk);
        check("flush_no_start", 64'(state_dbg), 64'd0);
        rv_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.result_valid) rv_seen++;
        end
        check("flush_no_result", 64'(rv_seen), 64'd0);
    endtask

    task automatic reset_test();
        @(posedge clk); #1;
        bus.op_valid_E = 1'b1;
        bus.op_E       = OP_MULT;
        bus.src_a_E    = 32'd3;
        bus.src_b_E    = 32'd5;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b0;
        #1;
        check("rst_mid_hi", 64'(bus.hi_out), 64'd0);
        check("rst_mid_lo", 64'(bus.lo_out), 64'd0);
        check("rst_mid_valid", 64'(bus.result_valid), 64'd0);
        check("rst_mid_stall", 64'(bus.stall_muldiv), 64'd0);
        check("rst_mid_state", 64'(state_dbg), 64'd0);
        @(posedge clk); #1;
        resetn         = 1'b1;
        bus.op_valid_E = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        bus.op_valid_E  = 1'b0;
        bus.op_E        = 2'd0;
        bus.src_a_E     = '0;
        bus.src_b_E     = '0;
        bus.flush_E     = 1'b0;
        bus.stall_other = 1'b0;
        resetn          = 1'b1;
        #1 resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hi", 64'(bus.hi_out), 64'd0);
        check("reset_lo", 64'(bus.lo_out), 64'd0);
        check("reset_valid", 64'(bus.result_valid), 64'd0);
        check("reset_stall", 64'(bus.stall_muldiv), 64'd0);
        check("reset_state", 64'(state_dbg), 64'd0);
        resetn = 1'b1;

        run_op(OP_MULTU, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_fffe, 32'h0000_0001, MUL_LAT, 0);
        run_op(OP_MULT,  32'hffff_ffff, 32'hffff_ffff, 32'h0000_0000, 32'h0000_0001, MUL_LAT, 0);
        run_op(OP_MULT,  32'h8000_0000, 32'h0000_0002, 32'hffff_ffff, 32'h0000_0000, MUL_LAT, 0);
        run_op(OP_DIV,   32'h0000_0007, 32'hffff_fffe, 32'h0000_0001, 32'hffff_fffd, DIV_LAT, 0);
        run_op(OP_DIVU,  32'hffff_ffff, 32'h0000_0010, 32'h0000_000f, 32'h0fff_ffff, DIV_LAT, 0);
        run_op(OP_DIVU,  32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hffff_ffff, DIV_LAT, 0);
        run_op(OP_DIV,   32'h8000_0000, 32'hffff_ffff, 32'h0000_0000, 32'h8000_0000, DIV_LAT, 0);
        run_op(OP_DIV,   32'hffff_fff9, 32'h0000_0002, 32'hffff_ffff, 32'hffff_fffd, DIV_LAT, 0);
        run_op(OP_DIV,   32'd100,       32'd7,         32'h0000_0002, 32'h0000_000e, DIV_LAT, 3);
        run_op(OP_DIV,   32'hffff_fff0, 32'h0000_0000, 32'hffff_fff0, 32'hffff_ffff, DIV_LAT, 0);
        run_op(OP_MULT,  32'h7fff_ffff, 32'h7fff_ffff, 32'h3fff_ffff, 32'h0000_0001, MUL_LAT, 2);

        flush_test();
        reset_test();
        run_op(OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, MUL_LAT, 0);

        repeat (3) @(posedge clk);
        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
